// File: rtl/cpu_pkg.sv
// Shared encodings for the execute stage: ALU op codes, forwarding selects and
// the multiply/divide FSM state.
package cpu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_LUI  = 4'd11,
      ALU_MULT = 4'd12,
      ALU_MULTU = 4'd13,
      ALU_DIV  = 4'd14,
      ALU_DIVU = 4'd15
   } alu_ctr_e;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_MEM = 2'd1;
   localparam logic [1:0] FWD_WB  = 2'd2;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } md_state_e;

   // Codes 12..15 are the multiply/divide group.
   function automatic logic is_md_op(input logic [3:0] code);
      return code[3] & code[2];
   endfunction

endpackage

// File: rtl/ex_md_stage_md_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle on operand magnitudes, sign fix-up on the last step.
module md_unit
   import cpu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int MD_ITER = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o,
   output logic            busy_o
);

   localparam int CW = $clog2(MD_ITER);

   md_state_e         state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic [XLEN-1:0]   dvd_q, dvd_d;
   logic              is_div_q, is_div_d;
   logic              neg_a_q, neg_a_d;
   logic              neg_b_q, neg_b_d;
   logic [XLEN-1:0]   hi_q, hi_d;
   logic [XLEN-1:0]   lo_q, lo_d;

   logic              neg_a, neg_b;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [XLEN:0]     mul_sum, div_shift, div_diff;
   logic [2*XLEN-1:0] mul_next, div_next, step, prod_fix;
   logic [XLEN-1:0]   quo, rem;

   always_comb begin
      // op_i[0] clear selects the signed flavour (MULT, DIV)
      neg_a = ~op_i[0] & a_i[XLEN-1];
      neg_b = ~op_i[0] & b_i[XLEN-1];
      mag_a = neg_a ? -a_i : a_i;
      mag_b = neg_b ? -b_i : b_i;

      // acc holds {partial product, remaining multiplier} or {remainder, quotient}
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};
      mul_next  = {mul_sum, acc_q[XLEN-1:1]};
      div_shift = acc_q[2*XLEN-1:XLEN-1];
      div_diff  = div_shift - {1'b0, opnd_q};
      div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                 : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      step      = is_div_q ? div_next : mul_next;

      prod_fix  = (neg_a_q ^ neg_b_q) ? -step : step;
      quo       = step[XLEN-1:0];
      rem       = step[2*XLEN-1:XLEN];
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      dvd_d    = dvd_q;
      is_div_d = is_div_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      case (state_q)
         MD_IDLE: begin
            if (start_i) begin
               state_d  = MD_RUN;
               count_d  = '0;
               is_div_d = op_i[1];
               neg_a_d  = neg_a;
               neg_b_d  = neg_b;
               dvd_d    = a_i;
               acc_d    = op_i[1] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
               opnd_d   = op_i[1] ? mag_b : mag_a;
            end
         end
         MD_RUN: begin
            acc_d   = step;
            count_d = count_q + 1'b1;
            if (count_q == CW'(MD_ITER - 1)) begin
               state_d = MD_IDLE;
               count_d = '0;
               if (!is_div_q) begin
                  hi_d = prod_fix[2*XLEN-1:XLEN];
                  lo_d = prod_fix[XLEN-1:0];
               end else if (opnd_q == '0) begin
                  hi_d = dvd_q;
                  lo_d = {XLEN{1'b1}};
               end else begin
                  // remainder follows the dividend's sign
                  lo_d = (neg_a_q ^ neg_b_q) ? -quo : quo;
                  hi_d = neg_a_q ? -rem : rem;
               end
            end
         end
         default: state_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= MD_IDLE;
         count_q  <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         dvd_q    <= '0;
         is_div_q <= 1'b0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         dvd_q    <= dvd_d;
         is_div_q <= is_div_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign hi_o   = hi_q;
   assign lo_o   = lo_q;
   assign busy_o = (state_q == MD_RUN);

endmodule

// File: rtl/ex_md_stage.sv
// Execute stage: operand forwarding, single-cycle ALU and the iterative
// multiply/divide unit with its busy stall back to the front end.
module ex_md_stage
   import cpu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int MD_ITER = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            valid_E,
   input  logic [3:0]      ALUctr_E,
   input  logic            ALUSrc_E,
   input  logic            ExtOp_E,
   input  logic [4:0]      shamt_E,
   input  logic [15:0]     imm16_E,
   input  logic [XLEN-1:0] rs_data_E,
   input  logic [XLEN-1:0] rt_data_E,
   input  logic [1:0]      fwd_a_sel,
   input  logic [1:0]      fwd_b_sel,
   input  logic [XLEN-1:0] fwd_mem_data,
   input  logic [XLEN-1:0] fwd_wb_data,
   input  logic            hilo_rd_E,
   output logic [XLEN-1:0] alu_result_o,
   output logic [XLEN-1:0] rt_fwd_o,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o,
   output logic            md_busy_o,
   output logic            stall_o
);

   logic [XLEN-1:0] op_a, rt_fwd, imm_ext, op_b;
   logic            is_md, md_start;
   alu_ctr_e        ctr;

   assign ctr = alu_ctr_e'(ALUctr_E);

   always_comb begin
      case (fwd_a_sel)
         FWD_MEM: op_a = fwd_mem_data;
         FWD_WB:  op_a = fwd_wb_data;
         default: op_a = rs_data_E;
      endcase
      case (fwd_b_sel)
         FWD_MEM: rt_fwd = fwd_mem_data;
         FWD_WB:  rt_fwd = fwd_wb_data;
         default: rt_fwd = rt_data_E;
      endcase
      imm_ext = ExtOp_E ? {{(XLEN-16){imm16_E[15]}}, imm16_E}
                        : {{(XLEN-16){1'b0}}, imm16_E};
      op_b    = ALUSrc_E ? imm_ext : rt_fwd;
   end

   always_comb begin
      alu_result_o = '0;
      case (ctr)
         ALU_ADD:  alu_result_o = op_a + op_b;
         ALU_SUB:  alu_result_o = op_a - op_b;
         ALU_AND:  alu_result_o = op_a & op_b;
         ALU_OR:   alu_result_o = op_a | op_b;
         ALU_XOR:  alu_result_o = op_a ^ op_b;
         ALU_NOR:  alu_result_o = ~(op_a | op_b);
         ALU_SLT:  alu_result_o = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         ALU_SLTU: alu_result_o = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         ALU_SLL:  alu_result_o = op_b << shamt_E;
         ALU_SRL:  alu_result_o = op_b >> shamt_E;
         ALU_SRA:  alu_result_o = $signed(op_b) >>> shamt_E;
         ALU_LUI:  alu_result_o = {imm16_E, {(XLEN-16){1'b0}}};
         default:  alu_result_o = '0;
      endcase
   end

   assign rt_fwd_o = rt_fwd;
   assign is_md    = is_md_op(ALUctr_E);
   // only MD ops and HI/LO reads care about the unit; everything else flows past
   assign stall_o  = md_busy_o & valid_E & (is_md | hilo_rd_E);
   assign md_start = valid_E & is_md & ~stall_o & ~md_busy_o;

   md_unit #(
      .XLEN    (XLEN),
      .MD_ITER (MD_ITER)
   ) u_md (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (md_start),
      .op_i    (ALUctr_E[1:0]),
      .a_i     (op_a),
      .b_i     (op_b),
      .hi_o    (hi_o),
      .lo_o    (lo_o),
      .busy_o  (md_busy_o)
   );

endmodule

// File: tb/tb_ex_md_stage.sv
// Directed checks of ex_md_stage: forwarding, ALU ops, MD timing/results,
// stall behaviour and reset abort.
module tb_ex_md_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_E;
   logic [3:0]  ALUctr_E;
   logic        ALUSrc_E;
   logic        ExtOp_E;
   logic [4:0]  shamt_E;
   logic [15:0] imm16_E;
   logic [31:0] rs_data_E, rt_data_E;
   logic [1:0]  fwd_a_sel, fwd_b_sel;
   logic [31:0] fwd_mem_data, fwd_wb_data;
   logic        hilo_rd_E;
   logic [31:0] alu_result_o, rt_fwd_o, hi_o, lo_o;
   logic        md_busy_o, stall_o;

   int checks = 0;
   int errors = 0;

   ex_md_stage #(.XLEN(32), .MD_ITER(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .valid_E      (valid_E),
      .ALUctr_E     (ALUctr_E),
      .ALUSrc_E     (ALUSrc_E),
      .ExtOp_E      (ExtOp_E),
      .shamt_E      (shamt_E),
      .imm16_E      (imm16_E),
      .rs_data_E    (rs_data_E),
      .rt_data_E    (rt_data_E),
      .fwd_a_sel    (fwd_a_sel),
      .fwd_b_sel    (fwd_b_sel),
      .fwd_mem_data (fwd_mem_data),
      .fwd_wb_data  (fwd_wb_data),
      .hilo_rd_E    (hilo_rd_E),
      .alu_result_o (alu_result_o),
      .rt_fwd_o     (rt_fwd_o),
      .hi_o         (hi_o),
      .lo_o         (lo_o),
      .md_busy_o    (md_busy_o),
      .stall_o      (stall_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic alu(input logic [3:0] ctr, input logic [31:0] a, input logic [31:0] b,
                      input logic src, input logic [15:0] imm, input logic [4:0] sh);
      ALUctr_E = ctr; rs_data_E = a; rt_data_E = b; ALUSrc_E = src;
      imm16_E = imm; shamt_E = sh; fwd_a_sel = 2'd0; fwd_b_sel = 2'd0; ExtOp_E = 1'b1;
      #1;
   endtask

   task automatic issue_md(input logic [3:0] ctr, input logic [31:0] a, input logic [31:0] b);
      valid_E = 1'b1; hilo_rd_E = 1'b0; ALUctr_E = ctr; ALUSrc_E = 1'b0;
      fwd_a_sel = 2'd0; fwd_b_sel = 2'd0; rs_data_E = a; rt_data_E = b;
   endtask

   task automatic run_md(input logic [3:0] ctr, input logic [31:0] a, input logic [31:0] b);
      issue_md(ctr, a, b);
      step();
      valid_E = 1'b0;
      repeat (32) step();
   endtask

   initial begin
      rst_n = 1'b0; valid_E = 1'b0; ALUctr_E = 4'd0; ALUSrc_E = 1'b0; ExtOp_E = 1'b0;
      shamt_E = 5'd0; imm16_E = 16'd0; rs_data_E = '0; rt_data_E = '0;
      fwd_a_sel = 2'd0; fwd_b_sel = 2'd0; fwd_mem_data = '0; fwd_wb_data = '0; hilo_rd_E = 1'b0;
      #2;
      chk("rst_hi", hi_o, 32'h0);
      chk("rst_lo", lo_o, 32'h0);
      chk("rst_busy", {31'b0, md_busy_o}, 32'h0);
      chk("rst_stall", {31'b0, stall_o}, 32'h0);
      step();
      rst_n = 1'b1;

      // forwarding
      alu(4'd0, 32'd5, 32'd0, 1'b1, 16'd1, 5'd0);
      fwd_mem_data = 32'd9; fwd_wb_data = 32'd100; fwd_a_sel = 2'd1; #1;
      chk("fwd_mem_add", alu_result_o, 32'd10);
      fwd_a_sel = 2'd2; #1;
      chk("fwd_wb_add", alu_result_o, 32'd101);
      fwd_a_sel = 2'd3; #1;
      chk("fwd_rsvd_add", alu_result_o, 32'd6);
      fwd_b_sel = 2'd1; #1;
      chk("rt_fwd_mem", rt_fwd_o, 32'd9);

      // ALU ops
      alu(4'd10, 32'd0, 32'h8000_0000, 1'b0, 16'd0, 5'd4);
      chk("sra", alu_result_o, 32'hF800_0000);
      alu(4'd9, 32'd0, 32'h8000_0000, 1'b0, 16'd0, 5'd4);
      chk("srl", alu_result_o, 32'h0800_0000);
      alu(4'd8, 32'd0, 32'h0000_0003, 1'b0, 16'd0, 5'd31);
      chk("sll", alu_result_o, 32'h8000_0000);
      alu(4'd6, 32'hFFFF_FFFF, 32'd1, 1'b0, 16'd0, 5'd0);
      chk("slt", alu_result_o, 32'd1);
      alu(4'd7, 32'hFFFF_FFFF, 32'd1, 1'b0, 16'd0, 5'd0);
      chk("sltu", alu_result_o, 32'd0);
      alu(4'd1, 32'd0, 32'd1, 1'b0, 16'd0, 5'd0);
      chk("sub_wrap", alu_result_o, 32'hFFFF_FFFF);
      alu(4'd0, 32'd5, 32'd0, 1'b1, 16'hFFFF, 5'd0);
      chk("add_sext", alu_result_o, 32'd4);
      ExtOp_E = 1'b0; #1;
      chk("add_zext", alu_result_o, 32'h0001_0004);
      alu(4'd5, 32'h0F0F_0000, 32'h0000_00F0, 1'b0, 16'd0, 5'd0);
      chk("nor", alu_result_o, 32'hF0F0_FF0F);
      alu(4'd11, 32'd0, 32'd0, 1'b0, 16'h1234, 5'd0);
      chk("lui", alu_result_o, 32'h1234_0000);
      alu(4'd12, 32'd5, 32'd7, 1'b0, 16'd0, 5'd0);
      chk("md_alu_zero", alu_result_o, 32'd0);

      // MULT -3 x 7 with cycle-accurate busy window
      issue_md(4'd12, 32'hFFFF_FFFD, 32'd7);
      #1;
      chk("idle_no_stall", {31'b0, stall_o}, 32'd0);
      step();
      valid_E = 1'b0;
      for (int i = 1; i <= 32; i++) begin
         chk($sformatf("mult_busy_%0d", i), {31'b0, md_busy_o}, 32'd1);
         step();
      end
      chk("mult_busy_end", {31'b0, md_busy_o}, 32'd0);
      chk("mult_hi", hi_o, 32'hFFFF_FFFF);
      chk("mult_lo", lo_o, 32'hFFFF_FFEB);

      // MULTU 2x3, then a DIV waits behind it; ADD and HI/LO read mixed in
      issue_md(4'd13, 32'd2, 32'd3);
      step();
      for (int i = 1; i <= 32; i++) begin
         if (i == 5) begin
            valid_E = 1'b1; hilo_rd_E = 1'b0; ALUctr_E = 4'd0; #1;
            chk("add_no_stall", {31'b0, stall_o}, 32'd0);
         end else if (i == 6) begin
            valid_E = 1'b1; hilo_rd_E = 1'b1; ALUctr_E = 4'd0; #1;
            chk("hilo_rd_stall", {31'b0, stall_o}, 32'd1);
         end else begin
            issue_md(4'd14, 32'hFFFF_FFF9, 32'd2); #1;
            chk($sformatf("md_stall_%0d", i), {31'b0, stall_o}, 32'd1);
         end
         step();
      end
      issue_md(4'd14, 32'hFFFF_FFF9, 32'd2); #1;
      chk("stall_release", {31'b0, stall_o}, 32'd0);
      chk("multu_lo", lo_o, 32'd6);
      chk("multu_hi", hi_o, 32'd0);
      step();
      valid_E = 1'b0;
      chk("div_started", {31'b0, md_busy_o}, 32'd1);
      repeat (32) step();
      chk("div_lo", lo_o, 32'hFFFF_FFFD);
      chk("div_hi", hi_o, 32'hFFFF_FFFF);

      run_md(4'd14, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("div_ovf_lo", lo_o, 32'h8000_0000);
      chk("div_ovf_hi", hi_o, 32'h0);

      run_md(4'd15, 32'd7, 32'd0);
      chk("divu0_lo", lo_o, 32'hFFFF_FFFF);
      chk("divu0_hi", hi_o, 32'd7);

      run_md(4'd15, 32'hFFFF_FFFF, 32'd16);
      chk("divu_lo", lo_o, 32'h0FFF_FFFF);
      chk("divu_hi", hi_o, 32'd15);

      // reset in the middle of a run
      issue_md(4'd12, 32'd5, 32'd5);
      step();
      valid_E = 1'b0;
      repeat (10) step();
      chk("pre_rst_busy", {31'b0, md_busy_o}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'b0, md_busy_o}, 32'd0);
      chk("abort_hi", hi_o, 32'd0);
      chk("abort_lo", lo_o, 32'd0);
      step();
      rst_n = 1'b1;
      repeat (40) step();
      chk("abort_no_write", lo_o, 32'd0);
      run_md(4'd12, 32'd2, 32'd3);
      chk("post_rst_lo", lo_o, 32'd6);
      chk("post_rst_hi", hi_o, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
